wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//   Writer side of the 8x8 register file: merges ALU and load writeback results onto the
//   single register-file write port (RegWrite/write_reg/write_data).
//   ALU results have priority; load results queue in a small FIFO.
//   A starvation limit guarantees queued loads drain, and WAW kill keeps writes in program order.
//   Sits between execute/memory stages and the register file; pending_mask feeds the hazard unit.
// PARAMETERS
//   DATA_W      8   register data width
//   ADDR_W      3   register index width (2**ADDR_W registers)
//   DEPTH       4   load FIFO entries, power of 2, >=2
//   STARVE_MAX  3   consecutive ALU wins allowed while FIFO holds a live entry (>=1)
// PORTS
//   clk           in   1        clock, all state on rising edge
//   reset         in   1        synchronous, active-high reset
//   alu_valid     in   1        ALU result present
//   alu_ready     out  1        ALU result accepted this cycle when alu_valid=1
//   alu_rd        in   ADDR_W   ALU destination register
//   alu_data      in   DATA_W   ALU result
//   mem_valid     in   1        load result present
//   mem_ready     out  1        FIFO can accept a load this cycle
//   mem_rd        in   ADDR_W   load destination register
//   mem_data      in   DATA_W   load data
//   RegWrite      out  1        register-file write enable (registered)
//   write_reg     out  ADDR_W   register-file write index (registered)
//   write_data    out  DATA_W   register-file write data (registered)
//   pending_mask  out  2**ADDR_W bit r=1: live (non-killed) queued load targets register r
// BEHAVIOUR
//   Reset (sync, clk edge with reset=1): FIFO empty, kill bits and starve_cnt cleared.
//     RegWrite=0, write_reg=0, write_data=0, pending_mask=0, alu_ready=1, mem_ready=1.
//     Reset dominates all inputs. Queued loads are discarded, never written.
//   Handshakes: alu_acc = alu_valid & alu_ready; mem_acc = mem_valid & mem_ready.
//     Upstream holds its valid/rd/data stable until accepted.
//   mem_ready = (count < DEPTH), from registered count only.
//     No same-cycle bypass. A pop in the same cycle does not raise mem_ready.
//   force_drain = FIFO non-empty & starve_cnt == STARVE_MAX; alu_ready = ~force_drain.
//   Per-cycle write selection, priority order:
//     1) alu_acc: next edge RegWrite=1, write_reg=alu_rd, write_data=alu_data. No pop.
//     2) else FIFO non-empty: pop head.
//        Head live: next edge RegWrite=1 with the head rd/data.
//        Head killed: RegWrite=0; the cycle is consumed.
//     3) else RegWrite=0. write_reg/write_data hold their last value.
//   Latency: ALU accept -> write 1 cycle. Load push -> earliest write 2 cycles (push, then pop).
//   FIFO order: strict first in, first out. Push and pop in the same cycle are legal.
//     In that case count is unchanged. Pointers wrap modulo DEPTH.
//   starve_cnt (0..STARVE_MAX), updated at each edge:
//     Cleared on any pop or when the FIFO is empty after the update.
//     Otherwise +1 on alu_acc while the FIFO is non-empty. Saturates at STARVE_MAX.
//     So at most STARVE_MAX ALU writes occur, then one forced pop cycle with alu_ready=0.
//   WAW kill: on alu_acc, every valid FIFO entry with rd == alu_rd sets its kill bit.
//     This includes a load pushed in the same cycle, which counts as older than the ALU result.
//     Kill bits are cleared on pop.
//   pending_mask: OR of one-hot(rd) over valid, non-killed entries, decoded from registered state.
//     Killed, popping or reset entries clear their bit on the next edge.
//   Width rules: rd and data pass through unmodified. No register index is treated specially.
// TESTING
//   T1 ALU only: alu_valid=1, rd=3, data=8'h5A, FIFO empty -> next cycle RegWrite=1, write_reg=3, write_data=5A; following cycle RegWrite=0.
//   T2 Load fill: push rd 1,2,3,4 (data 11,22,33,44) back-to-back, ALU idle -> mem_ready=0 after 4th push, writes appear r1..r4 in order, one per cycle, mem_ready returns to 1 one cycle after the first pop.
//   T3 Starvation: 1 load queued (r5=0x77), alu_valid held high with rd=6 -> 3 ALU writes, then alu_ready=0 for one cycle, r5=0x77 written, then ALU writes resume.
//   T4 WAW kill: load r2=0xAA queued, then ALU r2=0x55 accepted -> pending_mask[2]=0 next cycle, no write of 0xAA ever; a same-cycle load push to r2 is also killed.
//   T5 Boundary: FIFO full, pop and mem_valid in the same cycle -> mem_ready=0, nothing accepted; next cycle mem_ready=1, pointer wrap keeps data order intact.
//   T6 Reset mid-operation: FIFO holding 3 entries, reset pulsed 1 cycle -> next cycle all outputs at reset values, none of the queued data is ever written.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the single register-file write port.
// ALU results win; loads wait in a small FIFO. A starvation counter forces a pop after
// STARVE_MAX consecutive ALU wins, and WAW kill bits drop queued loads overwritten by a
// younger ALU result so register writes stay in program order.
module wb_write_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_W-1:0]       alu_rd,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [ADDR_W-1:0]       mem_rd,
  input  logic [DATA_W-1:0]       mem_data,
  output logic                    RegWrite,
  output logic [ADDR_W-1:0]       write_reg,
  output logic [DATA_W-1:0]       write_data,
  output logic [(1<<ADDR_W)-1:0]  pending_mask
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  // Load FIFO storage and per-entry status
  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  kill_q, kill_d;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [StW-1:0]    starve_q, starve_d;

  // Registered write port
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic fifo_nonempty, force_drain, alu_acc, mem_acc, pop;

  // Handshakes and arbitration decisions from registered state only
  always_comb begin
    fifo_nonempty = (count_q != '0);
    force_drain   = fifo_nonempty && (starve_q == StW'(STARVE_MAX));
    alu_ready     = ~force_drain;
    mem_ready     = (count_q < CntW'(DEPTH));
    alu_acc       = alu_valid & alu_ready;
    mem_acc       = mem_valid & mem_ready;
    pop           = ~alu_acc & fifo_nonempty;
  end

  // FIFO bookkeeping, WAW kill and starvation counter next state
  always_comb begin
    valid_d = valid_q;
    kill_d  = kill_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CntW'(mem_acc) - CntW'(pop);
    if (alu_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (rd_q[i] == alu_rd)) kill_d[i] = 1'b1;
      end
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      kill_d[head_q]  = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (mem_acc) begin
      valid_d[tail_q] = 1'b1;
      // A load pushed alongside an ALU result is older than it
      kill_d[tail_q]  = alu_acc && (mem_rd == alu_rd);
      tail_d          = tail_q + PtrW'(1);
    end
    if (pop || (count_d == '0)) begin
      starve_d = '0;
    end else if (alu_acc && fifo_nonempty && (starve_q != StW'(STARVE_MAX))) begin
      starve_d = starve_q + StW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Write port selection: ALU first, then FIFO head (killed heads burn the cycle)
  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (alu_acc) begin
      we_d    = 1'b1;
      wreg_d  = alu_rd;
      wdata_d = alu_data;
    end else if (pop && !kill_q[head_q]) begin
      we_d    = 1'b1;
      wreg_d  = rd_q[head_q];
      wdata_d = data_q[head_q];
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      kill_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      kill_q   <= kill_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  // FIFO payload; contents are don't-care while the entry is not valid
  always_ff @(posedge clk) begin
    if (mem_acc) begin
      rd_q[tail_q]   <= mem_rd;
      data_q[tail_q] <= mem_data;
    end
  end

  // Hazard view: registers targeted by live queued loads
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !kill_q[i]) pending_mask[rd_q[i]] = 1'b1;
    end
  end

  assign RegWrite   = we_q;
  assign write_reg  = wreg_q;
  assign write_data = wdata_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the writeback rules.
module tb_wb_write_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid, alu_ready, mem_valid, mem_ready, RegWrite;
  logic [2:0] alu_rd, mem_rd, write_reg;
  logic [7:0] alu_data, mem_data, write_data, pending_mask;

  always #5 clk = ~clk;

  wb_write_arbiter #(
    .DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .pending_mask(pending_mask)
  );

  typedef struct {
    logic [2:0] rd;
    logic [7:0] data;
    bit         killed;
  } ent_t;

  ent_t       mq[$];
  int         m_starve;
  logic       m_we;
  logic [2:0] m_reg;
  logic [7:0] m_data;
  bit         last_aacc, last_macc;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_we = 1'b0;
    m_reg = '0;
    m_data = '0;
  endtask

  // Compare every output against the model before the coming edge
  task automatic check_outputs(input string tag);
    logic [7:0] mask;
    mask = '0;
    foreach (mq[i]) if (!mq[i].killed) mask[mq[i].rd] = 1'b1;
    chk({tag, ".alu_ready"}, alu_ready, !(mq.size() != 0 && m_starve == STARVE_MAX));
    chk({tag, ".mem_ready"}, mem_ready, mq.size() < DEPTH);
    chk({tag, ".pending"}, pending_mask, mask);
    chk({tag, ".we"}, RegWrite, m_we);
    chk({tag, ".wreg"}, write_reg, m_reg);
    chk({tag, ".wdata"}, write_data, m_data);
  endtask

  // Apply one clock edge of the writeback rules to the model
  task automatic model_update();
    int   n;
    bit   ardy, aacc, macc, popped;
    ent_t h, e;
    last_aacc = 0;
    last_macc = 0;
    if (reset) begin
      model_reset();
      return;
    end
    n      = mq.size();
    ardy   = !(n != 0 && m_starve == STARVE_MAX);
    aacc   = alu_valid && ardy;
    macc   = mem_valid && (n < DEPTH);
    popped = 0;
    if (aacc) begin
      foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].killed = 1;
      m_we = 1'b1;
      m_reg = alu_rd;
      m_data = alu_data;
    end else if (n != 0) begin
      h = mq.pop_front();
      popped = 1;
      m_we = !h.killed;
      if (!h.killed) begin
        m_reg = h.rd;
        m_data = h.data;
      end
    end else begin
      m_we = 1'b0;
    end
    if (macc) begin
      e.rd = mem_rd;
      e.data = mem_data;
      e.killed = aacc && (mem_rd == alu_rd);
      mq.push_back(e);
    end
    if (popped || mq.size() == 0) m_starve = 0;
    else if (aacc && n != 0 && m_starve < STARVE_MAX) m_starve++;
    last_aacc = aacc;
    last_macc = macc;
  endtask

  task automatic step(input string tag);
    #2;
    check_outputs(tag);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input int ard, input int adat,
                       input bit mv, input int mrd, input int mdat);
    alu_valid = av;
    alu_rd = 3'(ard);
    alu_data = 8'(adat);
    mem_valid = mv;
    mem_rd = 3'(mrd);
    mem_data = 8'(mdat);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    chk("reset.we", RegWrite, 1'b0);
    chk("reset.ready", {alu_ready, mem_ready}, 2'b11);
    chk("reset.mask", pending_mask, 8'h00);

    // T1: single ALU write, one-cycle latency
    drive(1, 3, 8'h5A, 0, 0, 0);
    step("t1a");
    drive(0, 0, 0, 0, 0, 0);
    chk("t1.write", {RegWrite, write_reg, write_data}, {1'b1, 3'd3, 8'h5A});
    step("t1b");
    step("t1c");

    // T2/T5: fill the FIFO while the ALU wins, then push against a full FIFO during a pop
    for (int i = 0; i < 4; i++) begin
      drive(1, 7, 8'hE0 + i, 1, i + 1, 8'h11 * (i + 1));
      step("t2fill");
    end
    drive(0, 0, 0, 1, 5, 8'h55);
    chk("t5.full", {alu_ready, mem_ready}, 2'b00);
    step("t5full");
    chk("t5.reopen", mem_ready, 1'b1);
    step("t5push");
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("t2drain");

    // T3: starvation limit forces one pop among back-to-back ALU writes
    drive(0, 0, 0, 1, 5, 8'h77);
    step("t3push");
    for (int i = 0; i < 6; i++) begin
      drive(1, 6, 8'hC0 + i, 0, 0, 0);
      if (i == 3) chk("t3.drain", alu_ready, 1'b0);
      step("t3alu");
    end
    drive(0, 0, 0, 0, 0, 0);
    step("t3idle");

    // T4: WAW kill of a queued load and of a load pushed in the same cycle
    drive(0, 0, 0, 1, 2, 8'hAA);
    step("t4push");
    drive(1, 2, 8'h55, 1, 2, 8'hBB);
    step("t4kill");
    drive(0, 0, 0, 0, 0, 0);
    chk("t4.mask", pending_mask, 8'h00);
    for (int i = 0; i < 3; i++) step("t4drain");

    // T6: reset with three live entries discards them
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'h90 + i, 1, i + 4, 8'hD0 + i);
      step("t6fill");
    end
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("t6rst");
    reset = 1'b0;
    chk("t6.out", {RegWrite, write_reg, write_data, pending_mask}, 20'h0);
    for (int i = 0; i < 3; i++) step("t6idle");

    // Random traffic; upstream holds each request until it is accepted
    last_aacc = 0;
    last_macc = 0;
    for (int c = 0; c < 600; c++) begin
      if (!alu_valid || last_aacc)
        drive($urandom_range(0, 99) < 55, $urandom_range(0, 7), $urandom,
              mem_valid, mem_rd, mem_data);
      if (!mem_valid || last_macc) begin
        mem_valid = $urandom_range(0, 99) < 50;
        mem_rd = 3'($urandom_range(0, 7));
        mem_data = 8'($urandom);
      end
      reset = ($urandom_range(0, 79) == 0);
      step("rand");
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
